// File: rtl/stage_mem.sv
// stage_mem: memory-access stage; loads/stores run byte-serially over an 8-bit controller port.
// Non-memory instructions pass straight through to MEM/WB and the forwarding path.
module stage_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              valid_i,
    input  logic [7:0]        op_i,
    input  logic [2:0]        catagory_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_write_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [4:0]        rd_addr_o,
    output logic              rd_write_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              fwd_write_o,
    output logic [4:0]        fwd_addr_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              stall_o,
    output logic              mctl_req_o,
    output logic              mctl_we_o,
    output logic [ADDR_W-1:0] mctl_addr_o,
    output logic [7:0]        mctl_wdata_o,
    input  logic              mctl_ack_i,
    input  logic [7:0]        mctl_rdata_i
);
    localparam logic [7:0] OP_LB  = 8'h01;
    localparam logic [7:0] OP_LH  = 8'h02;
    localparam logic [7:0] OP_LBU = 8'h04;
    localparam logic [7:0] OP_LHU = 8'h05;
    localparam logic [7:0] OP_SB  = 8'h06;
    localparam logic [7:0] OP_SH  = 8'h07;
    localparam logic [2:0] CAT_LOAD  = 3'd1;
    localparam logic [2:0] CAT_STORE = 3'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] ld_buf_q, ld_buf_d;
    logic              is_load, is_mem, ack, busy, done, stall, wr;
    logic [1:0]        last_idx;
    logic [DATA_W-1:0] ld_ext;

    always_comb begin
        is_load  = valid_i && catagory_i == CAT_LOAD;
        is_mem   = is_load || (valid_i && catagory_i == CAT_STORE);
        last_idx = (op_i == OP_LB || op_i == OP_LBU || op_i == OP_SB) ? 2'd0 :
                   (op_i == OP_LH || op_i == OP_LHU || op_i == OP_SH) ? 2'd1 : 2'd3;
        ack      = rdy_in && mctl_ack_i && state_q == BUSY;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_buf_d = ld_buf_q;
        if (rdy_in && state_q == IDLE && is_mem) begin
            state_d = BUSY;
            cnt_d   = 2'd0;
        end
        if (rdy_in && state_q == DONE)
            state_d = IDLE;
        if (ack) begin
            if (is_load)
                ld_buf_d[{cnt_q, 3'b000} +: 8] = mctl_rdata_i;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == last_idx)
                state_d = DONE;
        end
    end

    always_comb begin
        ld_ext = op_i == OP_LB  ? {{(DATA_W-8){ld_buf_q[7]}}, ld_buf_q[7:0]} :
                 op_i == OP_LBU ? {{(DATA_W-8){1'b0}}, ld_buf_q[7:0]} :
                 op_i == OP_LH  ? {{(DATA_W-16){ld_buf_q[15]}}, ld_buf_q[15:0]} :
                 op_i == OP_LHU ? {{(DATA_W-16){1'b0}}, ld_buf_q[15:0]} : ld_buf_q;
        busy   = state_q == BUSY;
        done   = state_q == DONE;
        stall  = (state_q == IDLE && is_mem) || busy;
        // memory ops only write back in DONE, and only if they are loads
        wr     = valid_i && rd_write_i && (done ? is_load : !is_mem);
        rd_addr_o    = rd_addr_i;
        rd_data_o    = (done && is_load) ? ld_ext : rd_data_i;
        rd_write_o   = !rst_in && wr;
        fwd_write_o  = !rst_in && wr;
        fwd_addr_o   = rd_addr_i;
        fwd_data_o   = rd_data_o;
        stall_o      = !rst_in && stall;
        mctl_req_o   = !rst_in && rdy_in && busy;
        mctl_we_o    = busy && catagory_i == CAT_STORE;
        mctl_addr_o  = mem_addr_i + ADDR_W'(cnt_q);
        mctl_wdata_o = mem_data_i[{cnt_q, 3'b000} +: 8];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            ld_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_buf_q <= ld_buf_d;
        end
    end
endmodule
